seg_display_decoder: RTL and testbench

//  Loopback monitor for the 2-digit multiplexed 7-segment display path. Samples the driven

---
 rtl/seg_display_decoder.sv | 108 ++++++++++
 tb/tb_seg_display_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_decoder.sv
// seg_display_decoder: loopback monitor that decodes a 2-digit multiplexed 7-segment drive
// back into BCD digits and a 0..99 magnitude, delivered over a valid/ready handshake.
module seg_display_decoder #(
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] SEGMENTS,
    input  logic       DIGIT_SELECT,
    input  logic       READY,
    output logic [6:0] VALUE,
    output logic [3:0] TENS,
    output logic [3:0] ONES,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic {S_HUNT, S_ONES} state_t;

    logic [7:0]    r_q, p_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [3:0]    tens_q, tens_d, tens_o_q, tens_o_d, ones_o_q, ones_o_d, dig;
    logic          tens_err_q, tens_err_d, valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic          dig_err, cap, done, load, err;

    always_comb begin
        dig     = 4'd0;
        dig_err = 1'b0;
        case (r_q[6:0])
            7'b1111110: dig = 4'd0;
            7'b0110000: dig = 4'd1;
            7'b1101101: dig = 4'd2;
            7'b1111001: dig = 4'd3;
            7'b0110011: dig = 4'd4;
            7'b1011011: dig = 4'd5;
            7'b1011111: dig = 4'd6;
            7'b1110000: dig = 4'd7;
            7'b1111111: dig = 4'd8;
            7'b1110011: dig = 4'd9;
            default:    dig_err = 1'b1;
        endcase
    end

    // Counter parks at SETTLE_CYCLES so the capture strobe fires once per stable period
    assign cap   = (r_q == p_q) && (cnt_q == CW'(SETTLE_CYCLES - 1));
    assign cnt_d = (r_q != p_q) ? '0 : (cnt_q == CW'(SETTLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        tens_err_d = tens_err_q;
        done       = 1'b0;
        if (cap && !r_q[7]) begin
            tens_d     = dig;
            tens_err_d = dig_err;
            state_d    = S_ONES;
        end else if (cap && state_q == S_ONES) begin
            done    = 1'b1;
            state_d = S_HUNT;
        end
    end

    assign err      = tens_err_q | dig_err;
    assign load     = done && (!valid_q || READY);
    assign valid_d  = load | (valid_q & ~READY);
    assign ferr_d   = load ? err : ferr_q;
    assign tens_o_d = load ? (err ? 4'd0 : tens_q) : tens_o_q;
    assign ones_o_d = load ? (err ? 4'd0 : dig) : ones_o_q;
    assign ovr_d    = ovr_q | (done & valid_q & ~READY);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            state_q    <= S_HUNT;
            tens_q     <= '0;
            tens_err_q <= 1'b0;
            tens_o_q   <= '0;
            ones_o_q   <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            r_q        <= {DIGIT_SELECT, SEGMENTS};
            p_q        <= r_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            tens_q     <= tens_d;
            tens_err_q <= tens_err_d;
            tens_o_q   <= tens_o_d;
            ones_o_q   <= ones_o_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign VALUE     = {3'b000, tens_o_q} * 7'd10 + {3'b000, ones_o_q};
    assign TENS      = tens_o_q;
    assign ONES      = ones_o_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
endmodule

// File: tb/tb_seg_display_decoder.sv
// tb_seg_display_decoder: directed scenarios with hand-computed frames for the 7-segment loopback decoder.
module tb_seg_display_decoder;
    localparam int SETTLE = 1024;
    localparam logic [6:0] S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001, S4 = 7'b0110011,
                           S5 = 7'b1011011, S7 = 7'b1110000, S8 = 7'b1111111, S9 = 7'b1110011,
                           SBAD = 7'b0000001;

    logic        CLK = 1'b0, RESET = 1'b0, DIGIT_SELECT = 1'b0, READY = 1'b0;
    logic [6:0]  SEGMENTS = 7'd0;
    logic [6:0]  VALUE;
    logic [3:0]  TENS, ONES;
    logic        VALID, FRAME_ERR, OVERRUN;
    logic [17:0] obs, snap;
    int          vec_cnt = 0, err_cnt = 0, vcount = 0;

    seg_display_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .CLK(CLK), .RESET(RESET), .SEGMENTS(SEGMENTS), .DIGIT_SELECT(DIGIT_SELECT),
        .READY(READY), .VALUE(VALUE), .TENS(TENS), .ONES(ONES), .VALID(VALID),
        .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Observed word: {VALID, FRAME_ERR, OVERRUN, TENS, ONES, VALUE}
    assign obs = {VALID, FRAME_ERR, OVERRUN, TENS, ONES, VALUE};

    // Holds a pattern for n cycles, counting VALID cycles and snapshotting the first one
    task automatic hold(input logic ds, input logic [6:0] seg, input int n);
        DIGIT_SELECT = ds;
        SEGMENTS = seg;
        repeat (n) begin
            @(negedge CLK);
            if (VALID) begin
                vcount++;
                if (vcount == 1) snap = obs;
            end
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        vec_cnt++;
        if (obs !== 18'h0) begin err_cnt++; $display("FAIL reset_outputs: got %h expected %h", obs, 18'h0); end
        RESET = 1'b0;
    endtask

    task automatic test_basic_frame();
        READY = 1'b1;
        vcount = 0;
        hold(1'b0, S3, 2000);
        DIGIT_SELECT = 1'b1;
        SEGMENTS = S5;
        repeat (SETTLE + 1) @(negedge CLK);
        vec_cnt++;
        if (obs !== 18'h0) begin err_cnt++; $display("FAIL t2_before_latency: got %h expected %h", obs, 18'h0); end
        @(negedge CLK);
        vec_cnt++;
        if (obs !== {3'b100, 4'd3, 4'd5, 7'd35}) begin err_cnt++; $display("FAIL t2_frame35: got %h expected %h", obs, {3'b100, 4'd3, 4'd5, 7'd35}); end
        @(negedge CLK);
        vec_cnt++;
        if (obs !== {3'b000, 4'd3, 4'd5, 7'd35}) begin err_cnt++; $display("FAIL t2_valid_drop: got %h expected %h", obs, {3'b000, 4'd3, 4'd5, 7'd35}); end
        hold(1'b1, S5, 2000 - SETTLE - 3);
        vec_cnt++;
        if (vcount !== 0) begin err_cnt++; $display("FAIL t2_single_pulse: got %0d extra valid cycles expected 0", vcount); end
    endtask

    task automatic test_glitch_ones();
        vcount = 0;
        hold(1'b0, S3, 2000);
        hold(1'b1, S5, 500);
        vec_cnt++;
        if (vcount !== 0) begin err_cnt++; $display("FAIL t3_no_35: got %0d valid cycles expected 0", vcount); end
        DIGIT_SELECT = 1'b1;
        SEGMENTS = S9;
        repeat (SETTLE + 1) @(negedge CLK);
        vec_cnt++;
        if (obs !== {3'b000, 4'd3, 4'd5, 7'd35}) begin err_cnt++; $display("FAIL t3_before_latency: got %h expected %h", obs, {3'b000, 4'd3, 4'd5, 7'd35}); end
        @(negedge CLK);
        vec_cnt++;
        if (obs !== {3'b100, 4'd3, 4'd9, 7'd39}) begin err_cnt++; $display("FAIL t3_frame39: got %h expected %h", obs, {3'b100, 4'd3, 4'd9, 7'd39}); end
        hold(1'b1, S9, 2000 - SETTLE - 2);
    endtask

    task automatic test_frame_error();
        vcount = 0;
        hold(1'b0, SBAD, 2000);
        hold(1'b1, S1, 2000);
        vec_cnt++;
        if (vcount !== 1) begin err_cnt++; $display("FAIL t4_pulse_count: got %0d expected 1", vcount); end
        vec_cnt++;
        if (snap !== {3'b110, 4'd0, 4'd0, 7'd0}) begin err_cnt++; $display("FAIL t4_err_frame: got %h expected %h", snap, {3'b110, 4'd0, 4'd0, 7'd0}); end
    endtask

    task automatic test_overrun();
        READY = 1'b0;
        hold(1'b0, S1, 2000);
        hold(1'b1, S2, 2000);
        vec_cnt++;
        if (obs !== {3'b100, 4'd1, 4'd2, 7'd12}) begin err_cnt++; $display("FAIL t5_hold12: got %h expected %h", obs, {3'b100, 4'd1, 4'd2, 7'd12}); end
        hold(1'b0, S4, 2000);
        hold(1'b1, S7, 2000);
        vec_cnt++;
        if (obs !== {3'b101, 4'd1, 4'd2, 7'd12}) begin err_cnt++; $display("FAIL t5_overrun: got %h expected %h", obs, {3'b101, 4'd1, 4'd2, 7'd12}); end
        READY = 1'b1;
        @(negedge CLK);
        vec_cnt++;
        if (obs !== {3'b001, 4'd1, 4'd2, 7'd12}) begin err_cnt++; $display("FAIL t5_ready_drop: got %h expected %h", obs, {3'b001, 4'd1, 4'd2, 7'd12}); end
    endtask

    task automatic test_back_to_back();
        READY = 1'b0;
        do_reset();
        vec_cnt++;
        if (obs !== 18'h0) begin err_cnt++; $display("FAIL t5b_reset_clears: got %h expected %h", obs, 18'h0); end
        hold(1'b0, S1, 2000);
        hold(1'b1, S2, 2000);
        hold(1'b0, S4, 2000);
        DIGIT_SELECT = 1'b1;
        SEGMENTS = S7;
        repeat (SETTLE + 1) @(negedge CLK);
        vec_cnt++;
        if (obs !== {3'b100, 4'd1, 4'd2, 7'd12}) begin err_cnt++; $display("FAIL t5b_pre_pulse: got %h expected %h", obs, {3'b100, 4'd1, 4'd2, 7'd12}); end
        READY = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
        vec_cnt++;
        if (obs !== {3'b100, 4'd4, 4'd7, 7'd47}) begin err_cnt++; $display("FAIL t5b_frame47: got %h expected %h", obs, {3'b100, 4'd4, 4'd7, 7'd47}); end
        READY = 1'b1;
        @(negedge CLK);
        vec_cnt++;
        if (obs !== {3'b000, 4'd4, 4'd7, 7'd47}) begin err_cnt++; $display("FAIL t5b_accept47: got %h expected %h", obs, {3'b000, 4'd4, 4'd7, 7'd47}); end
    endtask

    task automatic test_midframe_reset();
        READY = 1'b1;
        vcount = 0;
        hold(1'b0, S8, 2000);
        hold(1'b1, S9, 100);
        RESET = 1'b1;
        hold(1'b1, S9, 3);
        vec_cnt++;
        if (obs !== 18'h0) begin err_cnt++; $display("FAIL t6_in_reset: got %h expected %h", obs, 18'h0); end
        RESET = 1'b0;
        vcount = 0;
        hold(1'b1, S9, 2000);
        vec_cnt++;
        if (vcount !== 0) begin err_cnt++; $display("FAIL t6_partial_dropped: got %0d valid cycles expected 0", vcount); end
        hold(1'b0, S2, 2000);
        hold(1'b1, S1, 2000);
        vec_cnt++;
        if (vcount !== 1) begin err_cnt++; $display("FAIL t6_pulse_count: got %0d expected 1", vcount); end
        vec_cnt++;
        if (snap !== {3'b100, 4'd2, 4'd1, 7'd21}) begin err_cnt++; $display("FAIL t6_frame21: got %h expected %h", snap, {3'b100, 4'd2, 4'd1, 7'd21}); end
    endtask

    initial begin
        snap = '0;
        @(negedge CLK);
        test_reset();
        test_basic_frame();
        test_glitch_ones();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
